// File: rtl/exec_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg
// Shared encodings for the execute stage:
//   alu_op_e    - ALUControlE codes
//   br_cond_e   - BranchCondE codes (RISC-V funct3 layout)
//   md_op_e     - MdOpE codes for the iterative multiply/divide unit
//   mdu_state_e - multiply/divide FSM states
//   fwd_sel_e   - ForwardAE / ForwardBE operand select codes
// -----------------------------------------------------------------------------
package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd4,
    BR_BGE  = 3'd5,
    BR_BLTU = 3'd6,
    BR_BGEU = 3'd7
  } br_cond_e;

  // Bit 1 selects divide, bit 0 selects the "upper" result register
  // (MULHU high product / REMU remainder).
  typedef enum logic [1:0] {
    MD_MUL   = 2'd0,
    MD_MULHU = 2'd1,
    MD_DIVU  = 2'd2,
    MD_REMU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/mul_div_iter.sv
// -----------------------------------------------------------------------------
// mul_div_iter
// Iterative unsigned multiply / divide, one result bit per clock.
//   MUL / MULHU : shift-add multiply, 2*XLEN product held in {acc_q, lo_q}
//   DIVU / REMU : restoring divide, remainder in acc_q, quotient in lo_q
// The FSM sits in BUSY for exactly XLEN cycles, then DONE for one cycle,
// then returns to IDLE.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   start_i   in   accept a new operation (only honoured in IDLE)
//   flush_i   in   abandon any operation, back to IDLE on the next edge
//   op_i      in   md_op_e operation code, latched with the operands
//   a_i, b_i  in   operands (a = multiplicand / dividend, b = multiplier / divisor)
//   idle_o    out  FSM is in IDLE
//   busy_o    out  FSM is in BUSY
//   done_o    out  FSM is in DONE, result_o is valid
//   result_o  out  selected result word
// -----------------------------------------------------------------------------
module mul_div_iter
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            idle_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       op_q,    op_d;
  logic [XLEN-1:0]  acc_q,   acc_d;    // product high half / remainder
  logic [XLEN-1:0]  lo_q,    lo_d;     // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0]  opnd_q,  opnd_d;   // multiplicand / divisor

  logic [XLEN:0]    mul_sum;
  logic [XLEN:0]    div_shift;
  logic [XLEN:0]    div_diff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    idle_o  = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;

    // Multiply step: conditionally add the multiplicand into the high half,
    // then shift the whole 2*XLEN product right by one.
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    // Divide step: bring the next dividend bit into the partial remainder and
    // try to subtract the divisor. The remainder always stays below the
    // divisor, so the shifted value never loses a bit. A zero divisor always
    // "succeeds", which naturally yields an all-ones quotient and leaves the
    // dividend in the remainder.
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};

    case (state_q)
      MDU_IDLE: begin
        idle_o = 1'b1;
        if (start_i) begin
          state_d = MDU_BUSY;
          cnt_d   = '0;
          acc_d   = '0;
          op_d    = op_i;
          if (op_i[1]) begin
            lo_d   = a_i;
            opnd_d = b_i;
          end else begin
            lo_d   = b_i;
            opnd_d = a_i;
          end
        end
      end
      MDU_BUSY: begin
        busy_o = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (op_q[1]) begin
          if (!div_diff[XLEN]) begin
            acc_d = div_diff[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = div_shift[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum[XLEN:1];
          lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == LAST_STEP) begin
          state_d = MDU_DONE;
        end
      end
      MDU_DONE: begin
        done_o  = 1'b1;
        state_d = MDU_IDLE;
      end
      default: begin
        state_d = MDU_IDLE;
      end
    endcase

    if (flush_i) begin
      state_d = MDU_IDLE;
    end
  end

  assign result_o = op_q[0] ? acc_q : lo_q;

endmodule

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
// Pipeline E stage: operand forwarding, ALU, branch/jump resolution, optional
// iterative multiply/divide unit, and the EX/MEM pipeline register.
//
// Build option
//   EXEC_MDU_EN - when defined, mul_div_iter and the stall logic are built in.
//                 When undefined, StallE is 0 and MulDivE/MdOpE are ignored
//                 (the instruction simply executes as its ALUControlE op).
//
// Ports
//   clk, reset                    clock; asynchronous active-low reset
//   FlushE                        kill the E-stage instruction
//   ForwardAE, ForwardBE          00 regfile, 01 ResultW, 10 ALUResultM, 11 regfile
//   RegWriteE, MemWriteE, JumpE,
//   BranchE, JalrE, ALUSrcE       decoded controls
//   ResultSrcE                    writeback select
//   ALUControlE                   alu_op_e
//   BranchCondE                   br_cond_e
//   MulDivE, MdOpE                multiply/divide request and md_op_e
//   RD1E, RD2E, PCE, ImmExtE,
//   PCPlus4E, ResultW             operands and forwarded writeback value
//   RdE                           destination register
//   PcSrcE, PCTargetE             fetch redirect and target
//   StallE                        hold F, D and E while the MDU works
//   RegWriteM .. RdM              EX/MEM register outputs
// -----------------------------------------------------------------------------
module execute_stage
  import exec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 FlushE,
  input  logic [1:0]           ForwardAE,
  input  logic [1:0]           ForwardBE,
  input  logic                 RegWriteE,
  input  logic                 MemWriteE,
  input  logic                 JumpE,
  input  logic                 BranchE,
  input  logic                 JalrE,
  input  logic                 ALUSrcE,
  input  logic [1:0]           ResultSrcE,
  input  logic [3:0]           ALUControlE,
  input  logic [2:0]           BranchCondE,
  input  logic                 MulDivE,
  input  logic [1:0]           MdOpE,
  input  logic [XLEN-1:0]      RD1E,
  input  logic [XLEN-1:0]      RD2E,
  input  logic [XLEN-1:0]      PCE,
  input  logic [XLEN-1:0]      ImmExtE,
  input  logic [XLEN-1:0]      PCPlus4E,
  input  logic [XLEN-1:0]      ResultW,
  input  logic [REGADDR_W-1:0] RdE,
  output logic                 PcSrcE,
  output logic [XLEN-1:0]      PCTargetE,
  output logic                 StallE,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic [1:0]           ResultSrcM,
  output logic [XLEN-1:0]      ALUResultM,
  output logic [XLEN-1:0]      WriteDataM,
  output logic [XLEN-1:0]      PCPlus4M,
  output logic [REGADDR_W-1:0] RdM
);

  localparam int SHW = (XLEN > 1) ? $clog2(XLEN) : 1;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] ex_result;
  logic [XLEN-1:0] jalr_sum;
  logic [SHW-1:0]  shamt;
  logic            bubble;

  // ---------------------------------------------------------------- forwarding
  always_comb begin
    case (ForwardAE)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      FWD_WB:  write_data = ResultW;
      FWD_MEM: write_data = ALUResultM;
      default: write_data = RD2E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : write_data;
  assign shamt = src_b[SHW-1:0];

  // ----------------------------------------------------------------------- ALU
  always_comb begin
    case (ALUControlE)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_AND:  alu_result = src_a & src_b;
      ALU_OR:   alu_result = src_a | src_b;
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SRA:  alu_result = $signed(src_a) >>> shamt;
      default:  alu_result = '0;
    endcase
  end

  // ------------------------------------------------------------- branch / jump
  // Branches always compare against the register operand, never the immediate.
  function automatic logic branch_cond(input logic [2:0]      cond,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    logic taken;
    case (cond)
      BR_BEQ:  taken = (a == b);
      BR_BNE:  taken = (a != b);
      BR_BLT:  taken = ($signed(a) <  $signed(b));
      BR_BGE:  taken = ($signed(a) >= $signed(b));
      BR_BLTU: taken = (a <  b);
      BR_BGEU: taken = (a >= b);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  assign PcSrcE = ((BranchE & branch_cond(BranchCondE, src_a, write_data)) | JumpE)
                  & ~StallE & ~FlushE;

  assign jalr_sum  = src_a + ImmExtE;
  assign PCTargetE = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + ImmExtE);

  // ------------------------------------------------------- multiply / divide
`ifdef EXEC_MDU_EN
  logic            mdu_idle;
  logic            mdu_busy;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_result;

  mul_div_iter #(
    .XLEN(XLEN)
  ) u_mdu (
    .clk      (clk),
    .reset    (reset),
    .start_i  (MulDivE & ~FlushE),
    .flush_i  (FlushE),
    .op_i     (MdOpE),
    .a_i      (src_a),
    .b_i      (src_b),
    .idle_o   (mdu_idle),
    .busy_o   (mdu_busy),
    .done_o   (mdu_done),
    .result_o (mdu_result)
  );

  // Stall through the accept cycle and every BUSY cycle; the DONE cycle lets
  // the result drop into EX/MEM. Held low during reset.
  assign StallE    = reset & MulDivE & (mdu_idle | mdu_busy);
  assign ex_result = mdu_done ? mdu_result : alu_result;
`else
  logic unused_mdu_inputs;
  assign unused_mdu_inputs = ^{MulDivE, MdOpE};
  assign StallE            = 1'b0;
  assign ex_result         = alu_result;
`endif

  // -------------------------------------------------------------- EX/MEM reg
  logic                 reg_write_q,  reg_write_d;
  logic                 mem_write_q,  mem_write_d;
  logic [1:0]           result_src_q, result_src_d;
  logic [XLEN-1:0]      alu_result_q, alu_result_d;
  logic [XLEN-1:0]      write_data_q, write_data_d;
  logic [XLEN-1:0]      pc_plus4_q,   pc_plus4_d;
  logic [REGADDR_W-1:0] rd_q,         rd_d;

  assign bubble = StallE | FlushE;

  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    result_src_d = '0;
    alu_result_d = '0;
    write_data_d = '0;
    pc_plus4_d   = '0;
    rd_d         = '0;
    if (!bubble) begin
      reg_write_d  = RegWriteE;
      mem_write_d  = MemWriteE;
      result_src_d = ResultSrcE;
      alu_result_d = ex_result;
      write_data_d = write_data;
      pc_plus4_d   = PCPlus4E;
      rd_d         = RdE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;
  assign RdM        = rd_q;

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
// Directed vectors with hand-computed expectations for execute_stage.
// Multiply/divide expectations depend on whether EXEC_MDU_EN is defined; when
// it is not, an MDU-tagged instruction is expected to behave as a plain ADD
// with no stall.
// -----------------------------------------------------------------------------
module tb_execute_stage;
  import exec_pkg::*;

  localparam int XLEN      = 32;
  localparam int REGADDR_W = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 FlushE;
  logic [1:0]           ForwardAE, ForwardBE;
  logic                 RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE;
  logic [1:0]           ResultSrcE;
  logic [3:0]           ALUControlE;
  logic [2:0]           BranchCondE;
  logic                 MulDivE;
  logic [1:0]           MdOpE;
  logic [XLEN-1:0]      RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
  logic [REGADDR_W-1:0] RdE;
  logic                 PcSrcE;
  logic [XLEN-1:0]      PCTargetE;
  logic                 StallE;
  logic                 RegWriteM, MemWriteM;
  logic [1:0]           ResultSrcM;
  logic [XLEN-1:0]      ALUResultM, WriteDataM, PCPlus4M;
  logic [REGADDR_W-1:0] RdM;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  execute_stage #(
    .XLEN(XLEN),
    .REGADDR_W(REGADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .JalrE(JalrE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .BranchCondE(BranchCondE),
    .MulDivE(MulDivE), .MdOpE(MdOpE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
    .PCPlus4E(PCPlus4E), .ResultW(ResultW), .RdE(RdE),
    .PcSrcE(PcSrcE), .PCTargetE(PCTargetE), .StallE(StallE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Returns 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    FlushE      = 1'b0;
    ForwardAE   = 2'b00;
    ForwardBE   = 2'b00;
    RegWriteE   = 1'b0;
    MemWriteE   = 1'b0;
    JumpE       = 1'b0;
    BranchE     = 1'b0;
    JalrE       = 1'b0;
    ALUSrcE     = 1'b0;
    ResultSrcE  = 2'b00;
    ALUControlE = ALU_ADD;
    BranchCondE = BR_BEQ;
    MulDivE     = 1'b0;
    MdOpE       = MD_MUL;
    RD1E        = '0;
    RD2E        = '0;
    PCE         = '0;
    ImmExtE     = '0;
    PCPlus4E    = '0;
    ResultW     = '0;
    RdE         = '0;
  endtask

  task automatic alu_op(input string tag, input logic [3:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    RD1E        = a;
    RD2E        = b;
    ALUControlE = ctrl;
    ALUSrcE     = 1'b0;
    RegWriteE   = 1'b1;
    tick();
    check_eq(tag, ALUResultM, exp);
  endtask

  // Operand A comes through the ResultW forward path and ResultW is changed
  // once the operation is under way, so a correct result also shows the
  // operands were captured at start.
  task automatic run_mdu(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] mdu_exp);
    int          n;
    int          exp_n;
    logic [31:0] exp_res;
    logic        rw_leak;
`ifdef EXEC_MDU_EN
    exp_n   = XLEN + 1;
    exp_res = mdu_exp;
`else
    exp_n   = 0;
    exp_res = a + b;
`endif
    clear_inputs();
    ForwardAE   = 2'b01;
    ResultW     = a;
    RD1E        = 32'hDEAD_0000;
    RD2E        = b;
    MulDivE     = 1'b1;
    MdOpE       = op;
    ALUControlE = ALU_ADD;
    RegWriteE   = 1'b1;
    RdE         = 5'd9;
    #1;
    n       = 0;
    rw_leak = 1'b0;
    while (StallE && n < 100) begin
      tick();
      n++;
      if (RegWriteM) rw_leak = 1'b1;
      if (n == 1) begin
        ResultW = ~a;
        #1;
      end
    end
    check_eq({tag, " stall cycles"}, n, exp_n);
    check_eq({tag, " bubble during stall"}, {31'd0, rw_leak}, 32'd0);
    tick();
    check_eq({tag, " result"}, ALUResultM, exp_res);
    check_eq({tag, " regwrite"}, {31'd0, RegWriteM}, 32'd1);
    check_eq({tag, " rd"}, {27'd0, RdM}, 32'd9);
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset   = 1'b0;
    MulDivE = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset stall low", {31'd0, StallE}, 32'd0);
    check_eq("reset regwrite", {31'd0, RegWriteM}, 32'd0);
    check_eq("reset aluresult", ALUResultM, 32'd0);
    check_eq("reset rd", {27'd0, RdM}, 32'd0);
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;

    // ---------------- ALU
    RdE      = 5'd3;
    PCPlus4E = 32'h44;
    alu_op("add", ALU_ADD, 32'd10, 32'd20, 32'd30);
    check_eq("add regwrite", {31'd0, RegWriteM}, 32'd1);
    check_eq("add writedata", WriteDataM, 32'd20);
    check_eq("add rd", {27'd0, RdM}, 32'd3);
    check_eq("add pcplus4", PCPlus4M, 32'h44);
    // asynchronous reset clears EX/MEM mid-cycle
    #2 reset = 1'b0;
    #1;
    check_eq("async reset aluresult", ALUResultM, 32'd0);
    check_eq("async reset regwrite", {31'd0, RegWriteM}, 32'd0);
    check_eq("async reset pcplus4", PCPlus4M, 32'd0);
    #1 reset = 1'b1;

    alu_op("sub", ALU_SUB, 32'd10, 32'd20, 32'hFFFF_FFF6);
    alu_op("and", ALU_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
    alu_op("or",  ALU_OR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
    alu_op("xor", ALU_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
    alu_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_op("sll shamt mask", ALU_SLL, 32'd1, 32'h21, 32'd2);
    alu_op("srl", ALU_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
    alu_op("srl 31", ALU_SRL, 32'h8000_0000, 32'h3F, 32'd1);
    alu_op("sra", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_op("unused code", 4'hF, 32'd5, 32'd6, 32'd0);
    alu_op("add wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1);

    // ---------------- forwarding
    clear_inputs();
    alu_op("fwd setup", ALU_ADD, 32'd2, 32'd3, 32'd5);
    ForwardAE = 2'b10; ALUSrcE = 1'b1; ImmExtE = 32'd3; RD1E = 32'h999;
    tick();
    check_eq("fwd A from mem", ALUResultM, 32'd8);
    ForwardAE = 2'b00; ForwardBE = 2'b10; ALUSrcE = 1'b0; RD1E = 32'd1; RD2E = 32'h777;
    tick();
    check_eq("fwd B from mem result", ALUResultM, 32'd9);
    check_eq("fwd B from mem writedata", WriteDataM, 32'd8);
    ForwardBE = 2'b01; ResultW = 32'h50; RD1E = 32'd0;
    tick();
    check_eq("fwd B from wb", WriteDataM, 32'h50);
    ForwardAE = 2'b11; ForwardBE = 2'b11; RD1E = 32'h33; RD2E = 32'h11;
    tick();
    check_eq("fwd code 11 regfile", ALUResultM, 32'h44);
    ForwardBE = 2'b00; ALUSrcE = 1'b1; ImmExtE = 32'h100; RD2E = 32'h5;
    tick();
    check_eq("imm srcb result", ALUResultM, 32'h133);
    check_eq("imm srcb writedata", WriteDataM, 32'h5);

    // ---------------- branch / jump
    clear_inputs();
    BranchE = 1'b1; BranchCondE = BR_BLTU;
    RD1E = 32'd1; RD2E = 32'hFFFF_FFFF; PCE = 32'h100; ImmExtE = 32'h20;
    #1;
    check_eq("bltu taken", {31'd0, PcSrcE}, 32'd1);
    check_eq("branch target", PCTargetE, 32'h120);
    BranchCondE = BR_BLT;  #1;
    check_eq("blt not taken", {31'd0, PcSrcE}, 32'd0);
    BranchCondE = BR_BGE;  #1;
    check_eq("bge taken", {31'd0, PcSrcE}, 32'd1);
    BranchCondE = BR_BGEU; #1;
    check_eq("bgeu not taken", {31'd0, PcSrcE}, 32'd0);
    BranchCondE = 3'd2; #1;
    check_eq("unused cond", {31'd0, PcSrcE}, 32'd0);
    BranchCondE = BR_BEQ; RD1E = 32'h20; RD2E = 32'd5; ALUSrcE = 1'b1; #1;
    check_eq("beq uses register not imm", {31'd0, PcSrcE}, 32'd0);
    BranchCondE = BR_BNE; #1;
    check_eq("bne taken", {31'd0, PcSrcE}, 32'd1);
    FlushE = 1'b1; #1;
    check_eq("flush gates pcsrc", {31'd0, PcSrcE}, 32'd0);
    clear_inputs();
    JumpE = 1'b1; JalrE = 1'b1; RD1E = 32'h1001; ImmExtE = 32'h10; #1;
    check_eq("jump pcsrc", {31'd0, PcSrcE}, 32'd1);
    check_eq("jalr target", PCTargetE, 32'h1010);
    JalrE = 1'b0; PCE = 32'hFFFF_FFF0; ImmExtE = 32'h20; #1;
    check_eq("target wrap", PCTargetE, 32'h10);

    // ---------------- flush bubble
    clear_inputs();
    RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 2'd2; RD1E = 32'd5; RD2E = 32'd6;
    RdE = 5'd7; PCPlus4E = 32'd8; FlushE = 1'b1;
    tick();
    check_eq("flush regwrite", {31'd0, RegWriteM}, 32'd0);
    check_eq("flush memwrite", {31'd0, MemWriteM}, 32'd0);
    check_eq("flush aluresult", ALUResultM, 32'd0);
    check_eq("flush rd", {27'd0, RdM}, 32'd0);
    FlushE = 1'b0;
    tick();
    check_eq("after flush memwrite", {31'd0, MemWriteM}, 32'd1);
    check_eq("after flush resultsrc", {30'd0, ResultSrcM}, 32'd2);
    check_eq("after flush aluresult", ALUResultM, 32'd11);

    // ---------------- multiply / divide
    run_mdu("mul 7x6", MD_MUL, 32'd7, 32'd6, 32'd42);
    run_mdu("mul lo", MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_mdu("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_mdu("divu 100/7", MD_DIVU, 32'd100, 32'd7, 32'd14);
    run_mdu("remu 100/7", MD_REMU, 32'd100, 32'd7, 32'd2);
    run_mdu("divu by 0", MD_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF);
    run_mdu("remu by 0", MD_REMU, 32'd100, 32'd0, 32'd100);
    run_mdu("divu big", MD_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

`ifdef EXEC_MDU_EN
    // flush in BUSY cycle 10
    clear_inputs();
    RD1E = 32'd7; RD2E = 32'd6; MulDivE = 1'b1; MdOpE = MD_MUL; RegWriteE = 1'b1; RdE = 5'd4;
    repeat (10) tick();
    check_eq("busy stall", {31'd0, StallE}, 32'd1);
    FlushE = 1'b1;
    tick();
    check_eq("busy flush regwrite", {31'd0, RegWriteM}, 32'd0);
    check_eq("busy flush aluresult", ALUResultM, 32'd0);
    run_mdu("mul after flush", MD_MUL, 32'd7, 32'd6, 32'd42);

    // reset in BUSY
    RD1E = 32'd7; RD2E = 32'd6; MulDivE = 1'b1; MdOpE = MD_MUL; RegWriteE = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    check_eq("busy reset stall", {31'd0, StallE}, 32'd0);
    check_eq("busy reset regwrite", {31'd0, RegWriteM}, 32'd0);
    check_eq("busy reset aluresult", ALUResultM, 32'd0);
    #1 reset = 1'b1;
    run_mdu("mul after reset", MD_MUL, 32'd9, 32'd3, 32'd27);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter REGADDR_W, default 5, destination register index width.
REQ-003 SHALL have the following ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- FlushE  in  1  kill the E-stage instruction.
- ForwardAE, ForwardBE  in  2 each  operand select: 00 register file, 01 ResultW, 10 ALUResultM.
- RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE  in  1 each  decoded controls.
- ResultSrcE  in  2  writeback select.
- ALUControlE  in  4  ALU operation.
- BranchCondE  in  3  branch compare: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- MulDivE  in  1  instruction uses the multiply/divide unit.
- MdOpE  in  2  MUL, MULHU, DIVU, REMU.
- RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW  in  XLEN each  operands and forwarded result.
- RdE  in  REGADDR_W  destination register.
- PcSrcE  out  1  redirect fetch.
- PCTargetE  out  XLEN  redirect address.
- StallE  out  1  hold F, D and E.
- RegWriteM, MemWriteM  out  1 each  registered controls.
- ResultSrcM  out  2  registered writeback select.
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN each  registered data.
- RdM  out  REGADDR_W  registered destination.

Function
REQ-004 SHALL select SrcA and forwarded WriteData by ForwardAE and ForwardBE; code 11 SHALL select the register-file value.
REQ-005 SrcB SHALL be ImmExtE when ALUSrcE=1, otherwise forwarded WriteData.
REQ-006 The ALU SHALL implement ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL and SRA, with shift amount SrcB[log2(XLEN)-1:0]; unused codes SHALL produce 0.
REQ-007 PcSrcE SHALL equal (BranchE & cond(BranchCondE, SrcA, SrcB_reg)) | JumpE, gated low while StallE=1 or FlushE=1; SrcB_reg is the forwarded register operand, never the immediate.
REQ-008 PCTargetE SHALL be PCE+ImmExtE, or (SrcA+ImmExtE)&~1 when JalrE=1; all additions wrap modulo 2^XLEN.
REQ-009 MDU FSM states SHALL be IDLE, BUSY and DONE.
REQ-010 IDLE->BUSY SHALL occur when MulDivE=1 and FlushE=0, latching SrcA, SrcB and MdOpE on that edge.
REQ-011 The FSM SHALL stay in BUSY for exactly XLEN cycles (shift-add multiply or restoring divide, one bit per cycle), then go to DONE.
REQ-012 DONE->IDLE SHALL occur unconditionally after one cycle.
REQ-013 StallE SHALL be high combinationally when MulDivE=1 and state is IDLE or BUSY; an MDU instruction therefore stalls for XLEN+1 cycles.
REQ-014 MUL SHALL return the low XLEN bits of the product; MULHU SHALL return the high XLEN bits.
REQ-015 DIVU by 0 SHALL return all ones; REMU by 0 SHALL return the dividend.
REQ-016 While StallE=1 or FlushE=1, the EX/MEM register SHALL load a bubble: RegWriteM=0, MemWriteM=0, all other M outputs 0.
REQ-017 Otherwise the EX/MEM register SHALL load on each edge, with ALUResultM taking the MDU result in DONE and the ALU result in all other states.
REQ-018 FlushE in BUSY or DONE SHALL force IDLE on the next edge, discard the result and load a bubble.
REQ-019 Operands latched at REQ-010 SHALL be insensitive to ResultW/ALUResultM changes during BUSY.

Reset
REQ-020 reset low SHALL asynchronously force the FSM to IDLE and clear the counter, latched operands and every M output to 0.
REQ-021 Reset mid-operation SHALL discard the MDU result; StallE SHALL be 0 while reset is low.

Configuration
REQ-022 With EXEC_MDU_EN defined, the FSM, MDU datapath and StallE logic SHALL be compiled in.
REQ-023 Without EXEC_MDU_EN, StallE SHALL be tied 0, MulDivE and MdOpE SHALL be ignored, and ALUResultM SHALL carry the ALU result (MulDivE treated as ALU ADD).

Structure
REQ-024 Package exec_pkg SHALL hold the ALUControl codes, BranchCond codes, MdOp codes and the MDU state enum.
REQ-025 The MDU datapath and FSM SHALL be sub-module mul_div_iter, parameterised by XLEN, with start/busy/done/result handshake.

Verification
REQ-026 RD1E=7, RD2E=6, MulDivE=1, MdOpE=MUL -> StallE high 33 cycles; next edge ALUResultM=42, RegWriteM=1.
REQ-027 DIVU 100/0 -> ALUResultM=0xFFFFFFFF; REMU 100/0 -> ALUResultM=100.
REQ-028 ForwardAE=10, ALUResultM=5, ADD with ImmExtE=3 -> ALUResultM=8 next edge.
REQ-029 BranchE=1, BLTU, SrcA=1, SrcB=0xFFFFFFFF, PCE=0x100, ImmExtE=0x20 -> PcSrcE=1, PCTargetE=0x120; same operands with BLT -> PcSrcE=0.
REQ-030 FlushE pulsed in BUSY cycle 10 -> IDLE next edge, RegWriteM stays 0; reset low in BUSY -> all M outputs 0 immediately.
